// File: rtl/wav_reset_seq.sv
// wav_reset_seq: sequenced release of NUM_CH active-high channel resets.
// After the block reset is synchronised away, channels are released in index
// order. Each enabled channel waits ch_delay[i] cycles. Disabled channels are
// skipped and left held in reset. A DFT override drives every channel reset
// from scan_asyncrst_ctrl while scan_mode is high.
//
// Ports:
//   clk                 block clock, rising edge
//   reset_n             async-assert, active-low block reset
//   scan_mode           DFT override enable
//   scan_asyncrst_ctrl  value forced onto ch_reset_out in scan
//   sw_reset            synchronous level request to restart the sequence
//   ch_enable[NUM_CH]   per-channel include (0 = held in reset, skipped)
//   ch_delay            channel i release delay at [i*CNT_W +: CNT_W]
//   ch_reset_out        active-high reset per channel
//   seq_done            all enabled channels released
//   seq_state           FSM state: RESET=00, COUNT=01, DONE=10
module wav_reset_seq #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      scan_mode,
  input  logic                      scan_asyncrst_ctrl,
  input  logic                      sw_reset,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH*CNT_W-1:0]   ch_delay,
  output logic [NUM_CH-1:0]         ch_reset_out,
  output logic                      seq_done,
  output logic [1:0]                seq_state
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d, nxt_idx;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]      ch_rst_q, ch_rst_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync_n;
  logic [CNT_W-1:0]       delay_arr [NUM_CH];

  // Unpack the flat delay bus into one entry per channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_delay
    assign delay_arr[g] = ch_delay[g*CNT_W +: CNT_W];
  end

  // Reset synchroniser: asserts immediately, deasserts after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

  // State, index, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RESET;
      idx_q    <= '0;
      cnt_q    <= '0;
      ch_rst_q <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ch_rst_q <= ch_rst_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ch_rst_d = ch_rst_q;
    done_d   = done_q;
    nxt_idx  = idx_q + IDX_W'(1);

    // A pending reset (sync or software) beats any release on the same edge.
    if (!rst_sync_n || sw_reset) begin
      state_d  = ST_RESET;
      idx_d    = '0;
      cnt_d    = '0;
      ch_rst_d = '1;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          state_d  = ST_COUNT;
          idx_d    = '0;
          cnt_d    = delay_arr[0];
          ch_rst_d = '1;
          done_d   = 1'b0;
        end
        ST_COUNT: begin
          if (ch_enable[idx_q] && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // Release (if enabled) and move on; disabled channels cost one cycle.
            if (ch_enable[idx_q]) begin
              ch_rst_d[idx_q] = 1'b0;
            end
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = nxt_idx;
              cnt_d = delay_arr[nxt_idx];
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d  = ST_RESET;
          ch_rst_d = '1;
          done_d   = 1'b0;
        end
      endcase
    end
  end

  // Scan override is purely combinational; the sequencer keeps running beneath it.
  assign ch_reset_out = scan_mode ? {NUM_CH{scan_asyncrst_ctrl}} : ch_rst_q;
  assign seq_done     = done_q & ~scan_mode;
  assign seq_state    = state_q;

endmodule

// File: tb/tb_wav_reset_seq.sv
// Directed bench for wav_reset_seq with default parameters (4 ch, 8-bit delay,
// 2-stage synchroniser). Inputs change and outputs are sampled on the falling
// edge; "Ek" is the k-th rising edge counted from the one entering COUNT.
module tb_wav_reset_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scan_mode;
  logic        scan_asyncrst_ctrl;
  logic        sw_reset;
  logic [3:0]  ch_enable;
  logic [31:0] ch_delay;
  logic [3:0]  ch_reset_out;
  logic        seq_done;
  logic [1:0]  seq_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wav_reset_seq #(.NUM_CH(4), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .scan_mode          (scan_mode),
    .scan_asyncrst_ctrl (scan_asyncrst_ctrl),
    .sw_reset           (sw_reset),
    .ch_enable          (ch_enable),
    .ch_delay           (ch_delay),
    .ch_reset_out       (ch_reset_out),
    .seq_done           (seq_done),
    .seq_state          (seq_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs after edge Ek given per-channel release edges.
  task automatic check_edge(input int k, input int r0, input int r1, input int r2,
                            input int r3, input logic [3:0] en, input int done_e);
    int          rel [4];
    logic [3:0]  m;
    rel[0] = r0; rel[1] = r1; rel[2] = r2; rel[3] = r3;
    m = 4'hf;
    for (int i = 0; i < 4; i++) begin
      if (en[i] && (k >= rel[i])) m[i] = 1'b0;
    end
    chk($sformatf("ch_reset_out@E%0d", k), 32'(ch_reset_out), 32'(m));
    chk($sformatf("seq_done@E%0d", k), 32'(seq_done), 32'(k >= done_e));
    chk($sformatf("seq_state@E%0d", k), 32'(seq_state), (k >= done_e) ? 32'h2 : 32'h1);
  endtask

  task automatic run_range(input int first, input int last, input int r0, input int r1,
                           input int r2, input int r3, input logic [3:0] en,
                           input int done_e);
    for (int k = first; k <= last; k++) begin
      step();
      check_edge(k, r0, r1, r2, r3, en, done_e);
    end
  endtask

  // Pulse sw_reset for one edge; returns just after E0 of the new sequence.
  task automatic restart();
    sw_reset = 1'b1;
    step();
    chk("restart_state", 32'(seq_state), 32'h0);
    chk("restart_ch", 32'(ch_reset_out), 32'hf);
    sw_reset = 1'b0;
    step();
    chk("restart_e0_state", 32'(seq_state), 32'h1);
    chk("restart_e0_ch", 32'(ch_reset_out), 32'hf);
  endtask

  initial begin
    reset_n            = 1'b1;
    scan_mode          = 1'b0;
    scan_asyncrst_ctrl = 1'b0;
    sw_reset           = 1'b0;
    ch_enable          = 4'hf;
    ch_delay           = {8'd1, 8'd5, 8'd0, 8'd3};
    #1 reset_n = 1'b0;
    #2;
    chk("rst_ch", 32'(ch_reset_out), 32'hf);
    chk("rst_done", 32'(seq_done), 32'h0);
    chk("rst_state", 32'(seq_state), 32'h0);

    // Base sequence: synchroniser costs two edges, third edge is E0.
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("sync_e1_state", 32'(seq_state), 32'h0);
    step();
    chk("sync_e2_state", 32'(seq_state), 32'h0);
    step();
    chk("base_e0_state", 32'(seq_state), 32'h1);
    chk("base_e0_ch", 32'(ch_reset_out), 32'hf);
    run_range(1, 15, 4, 5, 11, 13, 4'hf, 13);

    // Skip channel 1.
    ch_enable = 4'b1101;
    restart();
    run_range(1, 14, 4, 5, 11, 13, 4'b1101, 13);
    // Enable changes in DONE leave outputs alone.
    ch_enable = 4'hf;
    step();
    chk("done_en_hold_a", 32'(ch_reset_out), 32'h2);
    ch_enable = 4'h0;
    step();
    chk("done_en_hold_b", 32'(ch_reset_out), 32'h2);
    chk("done_en_hold_done", 32'(seq_done), 32'h1);
    ch_enable = 4'hf;

    // sw_reset at E8, sequence repeats from E9.
    restart();
    run_range(1, 7, 4, 5, 11, 13, 4'hf, 13);
    sw_reset = 1'b1;
    step();
    chk("swr_e8_ch", 32'(ch_reset_out), 32'hf);
    chk("swr_e8_state", 32'(seq_state), 32'h0);
    chk("swr_e8_done", 32'(seq_done), 32'h0);
    sw_reset = 1'b0;
    step();
    chk("swr_e9_state", 32'(seq_state), 32'h1);
    chk("swr_e9_ch", 32'(ch_reset_out), 32'hf);
    run_range(1, 13, 4, 5, 11, 13, 4'hf, 13);

    // Scan override in DONE.
    scan_mode = 1'b1;
    scan_asyncrst_ctrl = 1'b0;
    #1;
    chk("scan0_ch", 32'(ch_reset_out), 32'h0);
    chk("scan0_done", 32'(seq_done), 32'h0);
    chk("scan0_state", 32'(seq_state), 32'h2);
    scan_asyncrst_ctrl = 1'b1;
    #1;
    chk("scan1_ch", 32'(ch_reset_out), 32'hf);
    chk("scan1_done", 32'(seq_done), 32'h0);
    step();
    chk("scan1_clk_ch", 32'(ch_reset_out), 32'hf);
    chk("scan1_clk_state", 32'(seq_state), 32'h2);
    scan_asyncrst_ctrl = 1'b0;
    #1;
    chk("scan0b_ch", 32'(ch_reset_out), 32'h0);
    scan_asyncrst_ctrl = 1'b1;
    scan_mode = 1'b0;
    #1;
    chk("scan_off_ch", 32'(ch_reset_out), 32'h0);
    chk("scan_off_done", 32'(seq_done), 32'h1);
    scan_asyncrst_ctrl = 1'b0;

    // Async reset mid-COUNT, no clock edge involved.
    restart();
    run_range(1, 6, 4, 5, 11, 13, 4'hf, 13);
    #2 reset_n = 1'b0;
    #1;
    chk("async_ch", 32'(ch_reset_out), 32'hf);
    chk("async_done", 32'(seq_done), 32'h0);
    chk("async_state", 32'(seq_state), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("async_rel_e1_state", 32'(seq_state), 32'h0);
    step();
    chk("async_rel_e2_state", 32'(seq_state), 32'h0);
    step();
    chk("async_rel_e3_state", 32'(seq_state), 32'h1);
    chk("async_rel_e3_ch", 32'(ch_reset_out), 32'hf);
    run_range(1, 5, 4, 5, 11, 13, 4'hf, 13);

    // Delay edges {0,0,0,255}; delay bus changes during ch3's count are ignored.
    ch_delay = {8'd255, 8'd0, 8'd0, 8'd0};
    restart();
    run_range(1, 10, 1, 2, 3, 259, 4'hf, 259);
    ch_delay = {8'd5, 8'd7, 8'd9, 8'd2};
    run_range(11, 260, 1, 2, 3, 259, 4'hf, 259);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
